perf_counter_multi: RTL and testbench



---
 rtl/perf_counter_multi.sv | 168 ++++++++++++++++
 tb/tb_perf_counter_multi.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/perf_counter_multi.sv
// perf_counter_multi: NUM_SECTIONS-section Avalon-MM time/event performance counter with sticky overflow.
// Optional macro PERF_COUNTER_ATOMIC_READ_EN adds per-section high-word shadows for coherent 64-bit reads.
module perf_counter_multi #(
    parameter int NUM_SECTIONS = 4,
    parameter int TIME_W       = 64,
    parameter int EVENT_W      = 32,
    parameter int ADDR_W       = $clog2(NUM_SECTIONS) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              begintransfer,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
);
    localparam logic [TIME_W-1:0]  TIME_ONE = TIME_W'(1);
    localparam logic [EVENT_W-1:0] EVT_ONE  = EVENT_W'(1);

    logic                    wr;
    logic [ADDR_W-1:0]       sec_a;
    logic [1:0]              off_a;
    logic [NUM_SECTIONS-1:0] go_s, stop_s, clr_s, w1c_s;
    logic                    greset, genable;

    logic [TIME_W-1:0]       time_q [NUM_SECTIONS];
    logic [TIME_W-1:0]       time_d [NUM_SECTIONS];
    logic [EVENT_W-1:0]      evt_q  [NUM_SECTIONS];
    logic [EVENT_W-1:0]      evt_d  [NUM_SECTIONS];
    logic [NUM_SECTIONS-1:0] run_q, run_d, tovf_q, tovf_d, eovf_q, eovf_d;
    logic [31:0]             readdata_q, readdata_d;

    assign wr    = write & begintransfer;
    assign sec_a = address >> 2;
    assign off_a = address[1:0];

    always_comb begin
        go_s   = '0;
        stop_s = '0;
        clr_s  = '0;
        w1c_s  = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (wr && sec_a == ADDR_W'(s)) begin
                case (off_a)
                    2'd0:    stop_s[s] = 1'b1;
                    2'd1:    go_s[s]   = 1'b1;
                    2'd2:    clr_s[s]  = 1'b1;
                    default: w1c_s[s]  = 1'b1;
                endcase
            end
        end
    end

    // Section 0 gates every section; its own GO enables counting in the same cycle.
    assign greset  = stop_s[0] & writedata[0];
    assign genable = run_q[0] | go_s[0];

    always_comb begin
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            time_d[s] = time_q[s];
            evt_d[s]  = evt_q[s];
            run_d[s]  = run_q[s];
            tovf_d[s] = tovf_q[s];
            eovf_d[s] = eovf_q[s];
            if (go_s[s]) begin
                run_d[s] = 1'b1;
            end else if (stop_s[s]) begin
                run_d[s] = 1'b0;
            end
            // W1C is applied first so a same-cycle overflow set overrides it.
            if (w1c_s[s] && writedata[1]) tovf_d[s] = 1'b0;
            if (w1c_s[s] && writedata[2]) eovf_d[s] = 1'b0;
            if (run_q[s] && genable) begin
                time_d[s] = time_q[s] + TIME_ONE;
                if (&time_q[s]) tovf_d[s] = 1'b1;
            end
            if (go_s[s] && genable) begin
                evt_d[s] = evt_q[s] + EVT_ONE;
                if (&evt_q[s]) eovf_d[s] = 1'b1;
            end
            if (clr_s[s]) begin
                time_d[s] = '0;
                evt_d[s]  = '0;
                tovf_d[s] = 1'b0;
                eovf_d[s] = 1'b0;
            end
            if (greset) begin
                time_d[s] = '0;
                evt_d[s]  = '0;
                run_d[s]  = 1'b0;
                tovf_d[s] = 1'b0;
                eovf_d[s] = 1'b0;
            end
        end
    end

`ifdef PERF_COUNTER_ATOMIC_READ_EN
    logic                 rd;
    logic [TIME_W-33:0]   shd_q [NUM_SECTIONS];
    logic [TIME_W-33:0]   shd_d [NUM_SECTIONS];
    logic                 unused_wdata;

    assign rd           = read & begintransfer;
    assign unused_wdata = ^writedata[31:3];

    // A low-word read latches the matching high word for the following high-word read.
    always_comb begin
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            shd_d[s] = shd_q[s];
            if (rd && sec_a == ADDR_W'(s) && off_a == 2'd0) shd_d[s] = time_q[s][TIME_W-1:32];
            if (clr_s[s] || greset) shd_d[s] = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (reset) shd_q[s] <= '0;
            else       shd_q[s] <= shd_d[s];
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{writedata[31:3], read};
`endif

    always_comb begin
        readdata_d = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (sec_a == ADDR_W'(s)) begin
                case (off_a)
                    2'd0: readdata_d = time_q[s][31:0];
`ifdef PERF_COUNTER_ATOMIC_READ_EN
                    2'd1: readdata_d = 32'(shd_q[s]);
`else
                    2'd1: readdata_d = 32'(time_q[s][TIME_W-1:32]);
`endif
                    2'd2: readdata_d = 32'(evt_q[s]);
                    default: readdata_d = {29'b0, eovf_q[s], tovf_q[s], run_q[s]};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q      <= '0;
            tovf_q     <= '0;
            eovf_q     <= '0;
            readdata_q <= '0;
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                time_q[s] <= '0;
                evt_q[s]  <= '0;
            end
        end else begin
            run_q      <= run_d;
            tovf_q     <= tovf_d;
            eovf_q     <= eovf_d;
            readdata_q <= readdata_d;
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                time_q[s] <= time_d[s];
                evt_q[s]  <= evt_d[s];
            end
        end
    end

    assign readdata = readdata_q;
endmodule

// File: tb/tb_perf_counter_multi.sv
// Self-checking bench for perf_counter_multi: table of bus cycles with expected read data, plus
// hand-written carry/wrap/reset sequences using a preloaded time counter.
module tb_perf_counter_multi;
    localparam int NS = 5;
    localparam int TW = 33;
    localparam int EW = 4;
    localparam int AW = $clog2(NS) + 2;
`ifdef PERF_COUNTER_ATOMIC_READ_EN
    localparam logic [31:0] HI_COHERENT = 32'h0;
`else
    localparam logic [31:0] HI_COHERENT = 32'h1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic          begintransfer = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;

    int n_cmp = 0;
    int n_bad = 0;

    perf_counter_multi #(.NUM_SECTIONS(NS), .TIME_W(TW), .EVENT_W(EW)) dut (
        .clk(clk), .reset(reset), .address(address), .begintransfer(begintransfer),
        .write(write), .read(read), .writedata(writedata), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic          r;
        logic [AW-1:0] a;
        logic [31:0]   d;
        int            rpt;
        logic          chk;
        logic [31:0]   exp;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic w, input logic r, input int a, input logic [31:0] d,
                                input int rpt, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.w = w; v.r = r; v.a = AW'(a); v.d = d; v.rpt = rpt; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endfunction
    function automatic void add_w(input int a, input logic [31:0] d, input int n);
        add(1'b1, 1'b0, a, d, n, 1'b0, 32'h0);
    endfunction
    function automatic void add_r(input int a, input logic [31:0] exp);
        add(1'b0, 1'b1, a, 32'h0, 1, 1'b1, exp);
    endfunction
    function automatic void add_i(input int n);
        add(1'b0, 1'b0, 0, 32'h0, n, 1'b0, 32'h0);
    endfunction

    task automatic drive(input logic w, input logic r, input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        write = w; read = r; begintransfer = w | r; address = a; writedata = d;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: readdata=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic rchk(input string name, input int a, input logic [31:0] exp);
        drive(1'b0, 1'b1, AW'(a), 32'h0);
        @(posedge clk);
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // s0 alone: GO, 10 idle cycles, STOP
        add_w(1, 0, 1);  add_i(10);  add_w(0, 0, 1);
        add_r(0, 11);  add_r(1, 0);  add_r(2, 1);  add_r(3, 0);
        // s2 under a running s0, then global clear
        add_w(1, 0, 1);  add_w(9, 0, 1);  add_i(19);  add_w(8, 0, 1);
        add_r(8, 20);  add_r(11, 0);  add_r(10, 1);  add_r(0, 35);
        add_w(0, 1, 1);
        for (int a = 0; a < 4 * NS; a++) add_r(a, 0);
        // event wrap on s1, W1C, GO-while-running, unmapped reads
        add_w(1, 0, 1);  add_w(5, 0, 17);
        add_r(6, 1);  add_r(7, 5);  add_w(7, 4, 1);  add_r(7, 1);
        add_w(1, 0, 1);  add_r(2, 2);  add_r(3, 1);  add_r(20, 0);  add_r(29, 0);
        // CLEAR on a running s3 keeps it running
        add_w(13, 0, 1);  add_i(5);  add_w(14, 0, 1);
        add_r(12, 0);  add_r(14, 0);  add_r(15, 1);
        // STOP s0 freezes every section through genable
        add_w(0, 0, 1);  add_r(4, 36);  add_r(4, 36);  add_r(3, 0);  add_r(0, 37);  add_r(15, 1);

        repeat (3) drive(1'b0, 1'b0, '0, 32'h0);
        @(posedge clk);
        #1;
        check("reset_rdata", readdata, 32'h0);
        drive(1'b0, 1'b0, '0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].rpt; k++) drive(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
            if (vecs[i].chk) begin
                @(posedge clk);
                #1;
                check($sformatf("vec%0d_addr%0d", i, vecs[i].a), readdata, vecs[i].exp);
            end
        end

        // High-word carry with s0 preloaded just below 2^32
        drive(1'b0, 1'b0, '0, 32'h0);
        dut.time_q[0] = 33'h0_FFFF_FFFF;
        drive(1'b1, 1'b0, AW'(1), 32'h0);
        rchk("lo_before_carry", 0, 32'hFFFF_FFFF);
        rchk("hi_pair_read", 1, HI_COHERENT);
        rchk("lo_after_carry", 0, 32'h1);
        rchk("hi_after_carry", 1, 32'h1);

        // Wrap at 2^33 landing on the same cycle as a W1C of time_ovf
        drive(1'b1, 1'b0, AW'(0), 32'h0);
        drive(1'b0, 1'b0, '0, 32'h0);
        dut.time_q[0] = 33'h1_FFFF_FFFF;
        drive(1'b1, 1'b0, AW'(1), 32'h0);
        drive(1'b1, 1'b0, AW'(3), 32'h2);
        rchk("lo_after_wrap", 0, 32'h0);
        rchk("hi_after_wrap", 1, 32'h0);
        rchk("ovf_set_beats_w1c", 3, 32'h3);
        drive(1'b1, 1'b0, AW'(3), 32'h2);
        rchk("ovf_w1c", 3, 32'h1);

        // Reset mid-run; counting must not resume without a fresh GO
        drive(1'b0, 1'b0, '0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_rdata", readdata, 32'h0);
        drive(1'b0, 1'b0, '0, 32'h0);
        reset = 1'b0;
        repeat (2) drive(1'b0, 1'b0, '0, 32'h0);
        rchk("post_reset_status0", 3, 32'h0);
        rchk("post_reset_time0", 0, 32'h0);
        rchk("post_reset_evt1", 6, 32'h0);
        rchk("post_reset_status1", 7, 32'h0);

        drive(1'b0, 1'b0, '0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
